retry_fifo: RTL and testbench

Parametrised first-word-fall-through FIFO, successor to the 1-bit, 32-entry packet FIFO in the USB transmit path. It adds configurable width and depth, almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. It also adds a mark/rewind retry window: the protocol engine can replay a packet already read out, for example after a NAK or timeout, without the producer re-sending it. It sits between the bit-stream encoder/CRC stage and the bit stuffer.

---
 rtl/retry_fifo.sv | 102 ++++++++++
 tb/tb_retry_fifo.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retry_fifo.sv
// rtl/retry_fifo.sv - FWFT FIFO with almost/error flags, flush and mark/rewind retry window
module retry_fifo #(
    parameter int W      = 1,
    parameter int DEPTH  = 32,
    parameter int AFULL  = DEPTH - 4,
    parameter int AEMPTY = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [W-1:0]             data_in,
    input  logic                     re,
    output logic [W-1:0]             data_out,
    input  logic                     flush,
    input  logic                     mark,
    input  logic                     release_win,
    input  logic                     rewind,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   held
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] mk_ptr;
    logic [PW-1:0] rd_next;
    logic          win;
    logic          do_rewind;
    logic          rd_ok;
    logic          wr_ok;

    logic [W-1:0]  mem [DEPTH];

    // Occupancy, flags and accept decisions, all derived from registered pointers.
    always_comb begin
        count        = wr_ptr - rd_ptr;
        held         = wr_ptr - mk_ptr;
        full         = (held == PW'(DEPTH));
        empty        = (count == '0);
        almost_full  = (int'(held) >= AFULL);
        almost_empty = (int'(count) <= AEMPTY);
        do_rewind    = rewind & win;
        // A rewind replaces the pop in that cycle, so re is ignored.
        rd_ok        = re & ~empty & ~do_rewind & ~flush;
        // Full pass-through is only safe outside a window: inside one the
        // slot being popped is still retained for replay.
        wr_ok        = we & ~flush & (~full | (~win & rd_ok));
        rd_next      = do_rewind ? mk_ptr : (rd_ptr + PW'(rd_ok));
    end

    // Pointer, window and sticky error flag state.
    always_ff @(posedge clk) begin
        if (rst | flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mk_ptr    <= '0;
            win       <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_next;
            // Outside a window the mark shadows the read pointer so held == count.
            if (mark) begin
                win    <= 1'b1;
                mk_ptr <= rd_next;
            end else if (release_win) begin
                win    <= 1'b0;
                mk_ptr <= rd_next;
            end else if (!win) begin
                mk_ptr <= rd_next;
            end
            if (we & ~wr_ok) begin
                overflow <= 1'b1;
            end
            if (re & empty & ~do_rewind) begin
                underflow <= 1'b1;
            end
        end
    end

    // Storage array; no reset needed since data_out is undefined while empty.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

    assign data_out = mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_retry_fifo.sv
// tb/tb_retry_fifo.sv - self-checking bench for retry_fifo against a queue model
module tb_retry_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, we, re, flush, mark, release_win, rewind;
    logic [7:0] data_in;

    logic [7:0] dout8, dout4;
    logic       full8, empty8, af8, ae8, ov8, un8;
    logic       full4, empty4, af4, ae4, ov4, un4;
    logic [3:0] cnt8, held8;
    logic [2:0] cnt4, held4;

    retry_fifo #(.W(8), .DEPTH(8), .AFULL(4), .AEMPTY(4)) u8 (
        .clk(clk), .rst(rst), .we(we), .data_in(data_in), .re(re), .data_out(dout8),
        .flush(flush), .mark(mark), .release_win(release_win), .rewind(rewind),
        .full(full8), .empty(empty8), .almost_full(af8), .almost_empty(ae8),
        .overflow(ov8), .underflow(un8), .count(cnt8), .held(held8)
    );

    retry_fifo #(.W(8), .DEPTH(4), .AFULL(3), .AEMPTY(1)) u4 (
        .clk(clk), .rst(rst), .we(we), .data_in(data_in), .re(re), .data_out(dout4),
        .flush(flush), .mark(mark), .release_win(release_win), .rewind(rewind),
        .full(full4), .empty(empty4), .almost_full(af4), .almost_empty(ae4),
        .overflow(ov4), .underflow(un4), .count(cnt4), .held(held4)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: mq holds every retained entry from the mark onward,
    // rdi is how many of them have been read inside the current window.
    logic [7:0] mq[$];
    int  rdi  = 0;
    bit  mwin = 0;
    bit  mov  = 0;
    bit  mun  = 0;
    int  mdep = 8;

    function automatic int m_count();
        return mq.size() - rdi;
    endfunction

    function automatic int m_held();
        return mq.size();
    endfunction

    function automatic void m_drop();
        repeat (rdi) void'(mq.pop_front());
        rdi = 0;
    endfunction

    function automatic void model_step(input bit s_rst, input bit s_we, input logic [7:0] s_d,
                                       input bit s_re, input bit s_fl, input bit s_mk,
                                       input bit s_rl, input bit s_rw);
        bit is_full, is_empty, rwd, rok, wok;
        if (s_rst || s_fl) begin
            mq.delete();
            rdi  = 0;
            mwin = 0;
            mov  = 0;
            mun  = 0;
            return;
        end
        is_full  = (m_held() == mdep);
        is_empty = (m_count() == 0);
        rwd = s_rw && mwin;
        rok = s_re && !is_empty && !rwd;
        wok = s_we && (!is_full || (!mwin && rok));
        if (s_we && !wok) mov = 1;
        if (s_re && is_empty && !rwd) mun = 1;
        if (rwd) rdi = 0;
        else if (rok) rdi++;
        if (wok) mq.push_back(s_d);
        if (s_mk) begin
            mwin = 1;
            m_drop();
        end else if (s_rl) begin
            mwin = 0;
            m_drop();
        end else if (!mwin) begin
            m_drop();
        end
    endfunction

    task automatic tick(input bit t_rst, input bit t_we, input logic [7:0] t_d, input bit t_re,
                        input bit t_fl, input bit t_mk, input bit t_rl, input bit t_rw);
        rst = t_rst; we = t_we; data_in = t_d; re = t_re;
        flush = t_fl; mark = t_mk; release_win = t_rl; rewind = t_rw;
        model_step(t_rst, t_we, t_d, t_re, t_fl, t_mk, t_rl, t_rw);
        @(posedge clk);
        #1;
        rst = 0; we = 0; re = 0; flush = 0; mark = 0; release_win = 0; rewind = 0;
    endtask

    task automatic test_reset();
        mdep = 8;
        tick(1, 0, 8'h00, 0, 0, 0, 0, 0);
        total++;
        if ({empty8, ae8, full8, af8, ov8, un8} !== 6'b110000) begin
            bad++; $display("FAIL reset_flags got=%b want=110000", {empty8, ae8, full8, af8, ov8, un8});
        end
        total++;
        if (cnt8 !== 4'd0 || held8 !== 4'd0) begin
            bad++; $display("FAIL reset_counts got=%0d/%0d want=0/0", cnt8, held8);
        end
        total++;
        if (empty4 !== 1'b1 || cnt4 !== 3'd0) begin
            bad++; $display("FAIL reset_d4 got=%b/%0d want=1/0", empty4, cnt4);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            tick(0, 1, 8'(i), 0, 0, 0, 0, 0);
            total++;
            if (af8 !== 1'(i >= 4)) begin
                bad++; $display("FAIL fill_afull held=%0d got=%b want=%b", i, af8, 1'(i >= 4));
            end
        end
        total++;
        if (full8 !== 1'b1 || cnt8 !== 4'd8) begin
            bad++; $display("FAIL fill_full got=%b/%0d want=1/8", full8, cnt8);
        end
        tick(0, 1, 8'hFF, 0, 0, 0, 0, 0);
        total++;
        if (ov8 !== 1'b1 || cnt8 !== 4'd8) begin
            bad++; $display("FAIL fill_overflow got=%b/%0d want=1/8", ov8, cnt8);
        end
        for (int i = 1; i <= 8; i++) begin
            total++;
            if (dout8 !== 8'(i)) begin
                bad++; $display("FAIL drain_data got=%h want=%h", dout8, 8'(i));
            end
            tick(0, 0, 8'h00, 1, 0, 0, 0, 0);
        end
        total++;
        if (empty8 !== 1'b1) begin
            bad++; $display("FAIL drain_empty got=%b want=1", empty8);
        end
    endtask

    task automatic test_underflow_flush();
        tick(0, 0, 8'h00, 0, 1, 0, 0, 0);
        tick(0, 0, 8'h00, 1, 0, 0, 0, 0);
        total++;
        if (un8 !== 1'b1 || cnt8 !== 4'd0) begin
            bad++; $display("FAIL underflow got=%b/%0d want=1/0", un8, cnt8);
        end
        tick(0, 0, 8'h00, 0, 1, 0, 0, 0);
        total++;
        if (un8 !== 1'b0) begin
            bad++; $display("FAIL flush_clears got=%b want=0", un8);
        end
    endtask

    task automatic test_pass_through();
        tick(0, 0, 8'h00, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 8; i++) tick(0, 1, 8'(i), 0, 0, 0, 0, 0);
        tick(0, 1, 8'hAA, 1, 0, 0, 0, 0);
        total++;
        if (dout8 !== 8'h02 || cnt8 !== 4'd8 || ov8 !== 1'b0) begin
            bad++; $display("FAIL pass_through got=%h/%0d/%b want=02/8/0", dout8, cnt8, ov8);
        end
        for (int i = 2; i <= 9; i++) begin
            total++;
            if (dout8 !== ((i == 9) ? 8'hAA : 8'(i))) begin
                bad++; $display("FAIL pass_data got=%h want=%h", dout8, (i == 9) ? 8'hAA : 8'(i));
            end
            tick(0, 0, 8'h00, 1, 0, 0, 0, 0);
        end
    endtask

    task automatic test_retry_window();
        tick(0, 0, 8'h00, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 1, 8'h10 + 8'(i), 0, 0, 0, 0, 0);
        tick(0, 0, 8'h00, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 8'h00, 1, 0, 0, 0, 0);
        total++;
        if (empty8 !== 1'b1 || held8 !== 4'd4) begin
            bad++; $display("FAIL win_held got=%b/%0d want=1/4", empty8, held8);
        end
        tick(0, 0, 8'h00, 0, 0, 0, 0, 1);
        total++;
        if (cnt8 !== 4'd4 || dout8 !== 8'h10) begin
            bad++; $display("FAIL rewind got=%0d/%h want=4/10", cnt8, dout8);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (dout8 !== 8'h10 + 8'(i)) begin
                bad++; $display("FAIL reread got=%h want=%h", dout8, 8'h10 + 8'(i));
            end
            tick(0, 0, 8'h00, 1, 0, 0, 0, 0);
        end
        for (int i = 0; i < 4; i++) tick(0, 1, 8'h20 + 8'(i), 0, 0, 0, 0, 0);
        total++;
        if (full8 !== 1'b1 || cnt8 !== 4'd4 || held8 !== 4'd8) begin
            bad++; $display("FAIL win_full got=%b/%0d/%0d want=1/4/8", full8, cnt8, held8);
        end
        tick(0, 1, 8'h99, 1, 0, 0, 0, 0);
        total++;
        if (held8 !== 4'd8 || cnt8 !== 4'd3 || ov8 !== 1'b1) begin
            bad++; $display("FAIL win_block got=%0d/%0d/%b want=8/3/1", held8, cnt8, ov8);
        end
        for (int i = 1; i < 4; i++) begin
            total++;
            if (dout8 !== 8'h20 + 8'(i)) begin
                bad++; $display("FAIL win_tail got=%h want=%h", dout8, 8'h20 + 8'(i));
            end
            tick(0, 0, 8'h00, 1, 0, 0, 0, 0);
        end
        tick(0, 0, 8'h00, 0, 0, 0, 1, 0);
        total++;
        if (held8 !== 4'd0 || empty8 !== 1'b1) begin
            bad++; $display("FAIL release got=%0d/%b want=0/1", held8, empty8);
        end
    endtask

    task automatic test_random_window();
        bit r_we, r_re, r_fl, r_mk, r_rl, r_rw;
        mdep = 8;
        tick(0, 0, 8'h00, 0, 1, 0, 0, 0);
        for (int c = 0; c < 400; c++) begin
            r_we = 1'($urandom_range(0, 1));
            r_re = 1'($urandom_range(0, 1));
            r_mk = ($urandom_range(0, 9) == 0);
            r_rl = ($urandom_range(0, 9) == 0);
            r_rw = ($urandom_range(0, 7) == 0);
            r_fl = ($urandom_range(0, 59) == 0);
            if (m_count() > 0) begin
                total++;
                if (dout8 !== mq[rdi]) begin
                    bad++; $display("FAIL rand_data cyc=%0d got=%h want=%h", c, dout8, mq[rdi]);
                end
            end
            tick(0, r_we, 8'($urandom), r_re, r_fl, r_mk, r_rl, r_rw);
            total++;
            if (cnt8 !== 4'(m_count()) || held8 !== 4'(m_held())) begin
                bad++; $display("FAIL rand_counts cyc=%0d got=%0d/%0d want=%0d/%0d",
                                c, cnt8, held8, m_count(), m_held());
            end
            total++;
            if ({full8, empty8, af8, ae8, ov8, un8} !==
                {1'(m_held() == 8), 1'(m_count() == 0), 1'(m_held() >= 4), 1'(m_count() <= 4), mov, mun}) begin
                bad++; $display("FAIL rand_flags cyc=%0d got=%b want=%b", c,
                                {full8, empty8, af8, ae8, ov8, un8},
                                {1'(m_held() == 8), 1'(m_count() == 0), 1'(m_held() >= 4), 1'(m_count() <= 4), mov, mun});
            end
        end
    endtask

    task automatic test_wrap();
        int  nxt_w = 0;
        int  nxt_r = 0;
        int  cyc   = 0;
        bit  w, r, rok, wok;
        mdep = 4;
        tick(0, 0, 8'h00, 0, 1, 0, 0, 0);
        while (nxt_r < 100 && cyc < 3000) begin
            w   = (nxt_w < 100) && 1'($urandom_range(0, 1));
            r   = 1'($urandom_range(0, 1));
            rok = r && (m_count() > 0);
            wok = w && ((m_held() < 4) || rok);
            if (rok) begin
                total++;
                if (dout4 !== 8'(nxt_r)) begin
                    bad++; $display("FAIL wrap_data got=%h want=%h", dout4, 8'(nxt_r));
                end
                nxt_r++;
            end
            tick(0, w, 8'(nxt_w), r, 0, 0, 0, 0);
            if (wok) nxt_w++;
            total++;
            if ({full4, empty4} !== {1'(m_held() == 4), 1'(m_count() == 0)} || cnt4 !== 3'(m_count())) begin
                bad++; $display("FAIL wrap_flags cyc=%0d got=%b/%0d want=%b/%0d", cyc, {full4, empty4}, cnt4,
                                {1'(m_held() == 4), 1'(m_count() == 0)}, m_count());
            end
            cyc++;
        end
        total++;
        if (nxt_r != 100) begin
            bad++; $display("FAIL wrap_timeout got=%0d want=100", nxt_r);
        end
        mdep = 8;
    endtask

    task automatic test_reset_mid_window();
        mdep = 8;
        tick(0, 0, 8'h00, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 1, 8'h30 + 8'(i), 0, 0, 0, 0, 0);
        tick(0, 0, 8'h00, 0, 0, 1, 0, 0);
        tick(0, 0, 8'h00, 1, 0, 0, 0, 0);
        tick(0, 0, 8'h00, 1, 0, 0, 0, 0);
        tick(1, 0, 8'h00, 0, 0, 0, 0, 0);
        total++;
        if ({empty8, ae8, full8, af8, ov8, un8} !== 6'b110000 || cnt8 !== 4'd0 || held8 !== 4'd0) begin
            bad++; $display("FAIL midwin_reset got=%b/%0d/%0d want=110000/0/0",
                            {empty8, ae8, full8, af8, ov8, un8}, cnt8, held8);
        end
        tick(0, 0, 8'h00, 0, 0, 0, 0, 1);
        total++;
        if (cnt8 !== 4'd0 || empty8 !== 1'b1 || held8 !== 4'd0) begin
            bad++; $display("FAIL midwin_rewind got=%0d/%b/%0d want=0/1/0", cnt8, empty8, held8);
        end
    endtask

    initial begin
        rst = 1; we = 0; re = 0; flush = 0; mark = 0; release_win = 0; rewind = 0; data_in = 8'h00;
        test_reset();
        test_fill_drain();
        test_underflow_flush();
        test_pass_through();
        test_retry_window();
        test_random_window();
        test_wrap();
        test_reset_mid_window();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
